mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
MEM-stage data-memory access unit of the pipelined interrupt-capable CPU. It sits directly upstream of the MEM/WB register and drives its MD input. It turns load/store control from EX/MEM into a registered request/ready transaction on the data bus, and generates byte enables and store-data replication. It also sign- or zero-extends load data, raises address-error exceptions toward CP0, and stalls the pipeline while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, REQ-state cycles before the watchdog aborts (used only with the optional feature)
CNT_W, 5, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
valid_i  in  1  MEM-stage instruction valid
flush_i  in  1  CP0 exception flush; blocks a new access from starting
MemRead_i  in  1  load
MemWrite_i  in  1  store
MemSize_i  in  2  00 byte, 01 half, 10/11 word
MemSigned_i  in  1  1 = sign-extend load, 0 = zero-extend
ALUOut_mem_i  in  32  effective byte address
WD_i  in  32  store data (rt)
dm_rdata_i  in  32  bus read data, valid with dm_ready_i
dm_ready_i  in  1  bus completion strobe
dm_req_o  out  1  bus request, registered
dm_we_o  out  1  1 = write, registered
dm_addr_o  out  32  word-aligned address {addr[31:2],2'b00}, registered
dm_be_o  out  4  byte enables, registered
dm_wdata_o  out  32  lane-replicated store data, registered
MD_o  out  32  extended load data to MEM/WB MD_i, registered
stall_o  out  1  freeze IF..MEM stages
adel_o  out  1  load address error
ades_o  out  1  store address error
BadVAddr_o  out  32  faulting address (= ALUOut_mem_i)
bus_err_o  out  1  watchdog abort pulse (optional feature; otherwise tied 0)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o, MD_o, bus_err_o all 0; stall_o forced 0; watchdog counter 0.
- Access condition: start = valid_i & (MemRead_i|MemWrite_i) & ~misaligned & ~flush_i & state==IDLE. If MemRead_i and MemWrite_i are both 1, the access is treated as a store.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0. It combinationally raises adel_o (load) or ades_o (store) while valid_i=1. No bus request and no stall. BadVAddr_o = ALUOut_mem_i at all times.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1: stall_o=1 combinationally. At the clock edge, latch addr[1:0], size and signed into internal registers, load the dm_* outputs, set dm_req_o=1, and move to REQ.
- REQ: dm_req_o held at 1; stall_o=1. When dm_ready_i=1: for a load, capture the extended result into MD_o. At that edge dm_req_o goes to 0 and the state moves to DONE. Bus data/addr/be remain stable throughout REQ.
- DONE: stall_o=0 for exactly one cycle so MEM/WB captures MD_o. Next state is IDLE; the following MEM instruction is evaluated the next cycle.
- Latency: a zero-wait bus (ready in the first REQ cycle) gives 2 stall cycles. Each extra wait cycle adds one.
- flush_i is sampled only in IDLE. Once REQ is entered the transaction always completes; the bus cannot be aborted.
- Store lanes:
  - byte: be = 4'b0001<<addr[1:0]; wdata = {4{WD_i[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{WD_i[15:0]}}.
  - word: be = 1111; wdata = WD_i.
- Loads drive be=1111 and we=0. Byte/half are selected from dm_rdata_i using the latched addr[1:0], then extended per the latched signed bit. A word load is passed through unchanged.
- MD_o changes only on load completion; stores leave it unchanged.
- Reset asserted mid-REQ returns to IDLE with dm_req_o=0 immediately. The bus slave must ignore the dropped request.

Optional Feature:
MEM_TIMEOUT_EN. When defined:
- A CNT_W counter clears on REQ entry and increments each REQ cycle without dm_ready_i.
- On reaching TIMEOUT_CYCLES it forces REQ->DONE, pulses bus_err_o for one cycle, and leaves MD_o unchanged.
When undefined: no counter, bus_err_o tied 0, and REQ waits indefinitely.

Test Plan:
- LW addr 0x0000_0010, slave ready on first REQ cycle with rdata 0xDEADBEEF -> dm_addr_o 0x10, be 1111, we 0; stall_o high 2 cycles; MD_o=0xDEADBEEF in DONE.
- LB signed addr 0x13, rdata 0x80112233 -> MD_o=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x12 signed, rdata 0x8001xxxx -> 0xFFFF8001.
- SB addr 0x21, WD_i 0x000000AB -> be 0010, wdata 0xABABABAB, we 1. SH addr 0x22, WD_i 0x1234 -> be 1100, wdata 0x12341234. MD_o unchanged.
- LW addr 0x06 -> adel_o=1, BadVAddr_o=0x06, dm_req_o stays 0, stall_o 0. SH addr 0x05 -> ades_o=1.
- LW with 3 wait cycles -> stall_o high 5 cycles, then DONE. Drop rst mid-REQ -> dm_req_o=0 and MD_o=0 immediately, FSM in IDLE. flush_i=1 in IDLE with a load -> no request.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> bus_err_o pulse after 16 REQ cycles, stall released, MD_o unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: registered req/ready bus transaction, byte lanes, load extension.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  MemSize_i,
    input  logic        MemSigned_i,
    input  logic [31:0] ALUOut_mem_i,
    input  logic [31:0] WD_i,
    input  logic [31:0] dm_rdata_i,
    input  logic        dm_ready_i,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [3:0]  dm_be_o,
    output logic [31:0] dm_wdata_o,
    output logic [31:0] MD_o,
    output logic        stall_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] BadVAddr_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t     state;
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       sgn_q;

    logic is_half, is_word, misaligned, access, start, store;

    if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   extend_load = {{24{sgn & shifted[7]}}, shifted[7:0]};
            2'b01:   extend_load = {{16{sgn & half[15]}}, half};
            default: extend_load = rdata;
        endcase
    endfunction

    // Both read and write asserted is treated as a store.
    assign store      = MemWrite_i;
    assign access     = valid_i & (MemRead_i | MemWrite_i);
    assign is_half    = (MemSize_i == 2'b01);
    assign is_word    = MemSize_i[1];
    assign misaligned = (is_half & ALUOut_mem_i[0]) | (is_word & (|ALUOut_mem_i[1:0]));
    assign start      = access & ~misaligned & ~flush_i & (state == IDLE);

    assign adel_o     = valid_i & MemRead_i & ~MemWrite_i & misaligned;
    assign ades_o     = valid_i & MemWrite_i & misaligned;
    assign BadVAddr_o = ALUOut_mem_i;
    assign stall_o    = rst & (start | (state == REQ));

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`else
    assign bus_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            dm_req_o   <= 1'b0;
            dm_we_o    <= 1'b0;
            dm_addr_o  <= 32'h0;
            dm_be_o    <= 4'h0;
            dm_wdata_o <= 32'h0;
            MD_o       <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            cnt        <= '0;
            bus_err_o  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        off_q      <= ALUOut_mem_i[1:0];
                        size_q     <= MemSize_i;
                        sgn_q      <= MemSigned_i;
                        dm_req_o   <= 1'b1;
                        dm_we_o    <= store;
                        dm_addr_o  <= {ALUOut_mem_i[31:2], 2'b00};
                        dm_be_o    <= store ? lane_be(MemSize_i, ALUOut_mem_i[1:0]) : 4'b1111;
                        dm_wdata_o <= lane_wdata(MemSize_i, WD_i);
`ifdef MEM_TIMEOUT_EN
                        cnt        <= '0;
`endif
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dm_ready_i) begin
                        if (!dm_we_o) begin
                            MD_o <= extend_load(dm_rdata_i, off_q, size_q, sgn_q);
                        end
                        dm_req_o <= 1'b0;
                        state    <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the transaction; MD_o keeps its old value.
                        dm_req_o  <= 1'b0;
                        bus_err_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
`ifdef MEM_TIMEOUT_EN
                    bus_err_o <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
